// File: rtl/limn2600_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : limn2600_bus_pkg
//  Description : Shared definitions for the Limn2600 cs/we/rdy bus initiators.
//                Bus widths, the word size in bytes, and the DMA copier state
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package limn2600_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_LEN_W  = 16;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        GAP_R = 3'd2,
        WR    = 3'd3,
        GAP_W = 3'd4,
        FIN   = 3'd5
    } dma_state_t;

endpackage : limn2600_bus_pkg
`default_nettype wire

// File: rtl/limn2600_bus_initiator_port.sv
`default_nettype none
// ============================================================================
//  Module      : limn2600_bus_initiator_port
//  Description : Registered initiator side of the Limn2600 bus. A one-cycle
//                request launches a transfer; cs/we/addr/data_out are then
//                held until the responder strobes rdy or the wait timer
//                expires. Read data is captured on the completing edge.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n        clock, asynchronous active-low reset
//    i_req             launch a transfer this edge (only while cs is low)
//    i_we/i_addr/i_wdata  transfer attributes sampled with i_req
//    o_ack             cs=1 and rdy=1: transfer completes on this edge
//    o_timeout         cs held TIMEOUT cycles without rdy; cs drops this edge
//    o_rdata           last captured read word
//    o_cs/o_we/o_addr/o_data_out  bus outputs
//    i_data_in/i_rdy   bus inputs from the responder
// ============================================================================
module limn2600_bus_initiator_port
    import limn2600_bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ack,
    output logic              o_timeout,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_cs,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data_out,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_rdy
);

    // Wide enough to hold TIMEOUT-1; a 1-bit counter when the timeout is
    // disabled or trivially short.
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic              r_cs;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [TMR_W-1:0]  r_timer;

    logic              w_ack;
    logic              w_timeout;

    // rdy outside a cs window is ignored by construction.
    assign w_ack = r_cs & i_rdy;

    generate
        if (TIMEOUT != 0) begin : g_timeout_en
            // Fires in the TIMEOUT-th consecutive cycle of cs without rdy, so
            // cs is seen high for exactly TIMEOUT cycles.
            assign w_timeout = r_cs & ~i_rdy & (r_timer == TMR_W'(TIMEOUT - 1));
        end else begin : g_timeout_dis
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_timer <= '0;
        end else begin
            if (i_req) begin
                r_cs    <= 1'b1;
                r_we    <= i_we;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_timer <= '0;
            end else if (w_ack || w_timeout) begin
                // Attributes stay parked; only cs frames the transfer.
                r_cs <= 1'b0;
            end else if (r_cs) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (w_ack && !r_we) begin
                r_rdata <= i_data_in;
            end
        end
    end

    assign o_ack      = w_ack;
    assign o_timeout  = w_timeout;
    assign o_rdata    = r_rdata;
    assign o_cs       = r_cs;
    assign o_we       = r_we;
    assign o_addr     = r_addr;
    assign o_data_out = r_wdata;

endmodule : limn2600_bus_initiator_port
`default_nettype wire

// File: rtl/limn2600_dma_copier.sv
`default_nettype none
// ============================================================================
//  Module      : limn2600_dma_copier
//  Description : Word-granular memory-to-memory copy engine acting as a bus
//                initiator. Each word is one read followed by one write, with
//                a single idle cs cycle between transfers.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n        clock, asynchronous active-low reset
//    i_start           copy request, honoured only while idle
//    i_src/i_dst       byte addresses, low two bits ignored
//    i_len             word count
//    i_abort           stop at the next write boundary
//    o_busy            copy in progress
//    o_done            one-cycle completion pulse
//    o_err             sticky timeout flag, cleared by the next accepted start
//    o_remaining       words not yet written
//    o_cs/o_we/o_addr/o_data_out, i_data_in/i_rdy  Limn2600 bus
// ============================================================================
module limn2600_dma_copier
    import limn2600_bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int LEN_W   = BUS_LEN_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [LEN_W-1:0]  o_remaining,
    output logic              o_cs,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data_out,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_rdy
);

    localparam logic [ADDR_W-1:0] C_WORD_INC   = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

    dma_state_t        r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_abort;

    logic [ADDR_W-1:0] w_src_al;
    logic [ADDR_W-1:0] w_dst_al;
    logic              w_stop;
    logic              w_req;
    logic              w_req_we;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_ack;
    logic              w_timeout;
    logic [DATA_W-1:0] w_buffer;

    assign w_src_al = i_src & C_ALIGN_MASK;
    assign w_dst_al = i_dst & C_ALIGN_MASK;

    // An abort arriving in the GAP_W cycle itself still stops at this
    // boundary rather than costing another full word.
    assign w_stop = (r_remaining == '0) | r_abort | i_abort;

    // Bus launches coincide with the state transition into RD/WR so that cs
    // is high for the whole time the FSM sits in RD/WR.
    always_comb begin
        w_req      = 1'b0;
        w_req_we   = 1'b0;
        w_req_addr = r_src;
        case (r_state)
            IDLE: begin
                if (i_start && (i_len != '0)) begin
                    w_req      = 1'b1;
                    w_req_addr = w_src_al;
                end
            end
            GAP_R: begin
                w_req      = 1'b1;
                w_req_we   = 1'b1;
                w_req_addr = r_dst;
            end
            GAP_W: begin
                if (!w_stop) begin
                    w_req = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort && (r_state != IDLE)) begin
                r_abort <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_abort <= 1'b0;
                    if (i_start) begin
                        r_src       <= w_src_al;
                        r_dst       <= w_dst_al;
                        r_remaining <= i_len;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= (i_len == '0) ? FIN : RD;
                    end
                end
                RD: begin
                    // Timeout and ack are mutually exclusive (timeout needs !rdy).
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= FIN;
                    end else if (w_ack) begin
                        r_src   <= r_src + C_WORD_INC;
                        r_state <= GAP_R;
                    end
                end
                GAP_R: begin
                    r_state <= WR;
                end
                WR: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= FIN;
                    end else if (w_ack) begin
                        r_dst       <= r_dst + C_WORD_INC;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_state     <= GAP_W;
                    end
                end
                GAP_W: begin
                    r_state <= w_stop ? FIN : RD;
                end
                FIN: begin
                    // done/busy are registered, so the pulse lands in the
                    // first IDLE cycle with busy already low.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_abort <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    limn2600_bus_initiator_port #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (w_req),
        .i_we       (w_req_we),
        .i_addr     (w_req_addr),
        .i_wdata    (w_buffer),
        .o_ack      (w_ack),
        .o_timeout  (w_timeout),
        .o_rdata    (w_buffer),
        .o_cs       (o_cs),
        .o_we       (o_we),
        .o_addr     (o_addr),
        .o_data_out (o_data_out),
        .i_data_in  (i_data_in),
        .i_rdy      (i_rdy)
    );

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_remaining = r_remaining;

endmodule : limn2600_dma_copier
`default_nettype wire

// File: tb/tb_limn2600_dma_copier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_limn2600_dma_copier
//  Description : Self-checking bench for limn2600_dma_copier. A word-addressed
//                memory responder with random wait states serves the bus; the
//                expected bus trace and memory image come from a plain
//                word-by-word copy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_limn2600_dma_copier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_src = '0;
    logic [31:0] i_dst = '0;
    logic [15:0] i_len = '0;
    logic        i_abort = 1'b0;
    logic        o_busy, o_done, o_err;
    logic [15:0] o_remaining;
    logic        o_cs, o_we;
    logic [31:0] o_addr, o_data_out;
    logic [31:0] i_data_in = '0;
    logic        i_rdy = 1'b0;

    limn2600_dma_copier #(
        .ADDR_W (32), .DATA_W (32), .LEN_W (16), .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_src       (i_src),
        .i_dst       (i_dst),
        .i_len       (i_len),
        .i_abort     (i_abort),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_remaining (o_remaining),
        .o_cs        (o_cs),
        .o_we        (o_we),
        .o_addr      (o_addr),
        .o_data_out  (o_data_out),
        .i_data_in   (i_data_in),
        .i_rdy       (i_rdy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    bit [31:0] mem [bit [31:0]];
    bit        dead = 1'b0;
    int        wcnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            i_rdy <= 1'b0;
            wcnt = 0;
        end else if (i_rdy) begin
            i_rdy <= 1'b0;
            if (o_cs && o_we) mem[o_addr] = o_data_out;
            wcnt = $urandom_range(0, 4);
        end else if (o_cs && !dead) begin
            if (wcnt == 0) begin
                i_rdy     <= 1'b1;
                i_data_in <= o_we ? $urandom : mem[o_addr];
            end else begin
                wcnt--;
            end
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] data;
        int        t_start;
        int        t_end;
    } xfer_t;

    xfer_t     log_q [$];
    int        cyc_ctr = 0;
    int        cur_start = 0;
    int        stab_bad = 0;
    bit        pcs = 1'b0, prdy = 1'b0, pwe = 1'b0;
    bit [31:0] paddr = '0, pdata = '0;

    always @(posedge clk) begin
        cyc_ctr++;
        if (o_cs && !pcs) cur_start = cyc_ctr;
        if (o_cs && pcs && !prdy &&
            (o_addr !== paddr || o_we !== pwe || (o_we && o_data_out !== pdata)))
            stab_bad++;
        if (o_cs && i_rdy)
            log_q.push_back('{o_we, o_addr, (o_we ? o_data_out : i_data_in), cur_start, cyc_ctr});
        pcs   = o_cs;
        prdy  = i_rdy;
        pwe   = o_we;
        paddr = o_addr;
        pdata = o_data_out;
    end

    // ---------------- one copy against the reference model ----------------
    task automatic run_copy(input string tag, input bit [31:0] src, input bit [31:0] dst,
                            input int len, input int abort_k, input bit spam);
        bit [31:0] s, d;
        int        n, exp_rem, done_at, busy_cyc, cs_cyc, cyc, rd_idx, base, stab0, bad, nlog;
        bit        exp_err, prev_cs;
        bit [31:0] keep [$];
        xfer_t     exp_q [$];

        s = src & 32'hFFFF_FFFC;
        d = dst & 32'hFFFF_FFFC;
        exp_err = dead && (len != 0);
        n = exp_err ? 0 : ((abort_k > 0 && abort_k < len) ? abort_k : len);
        exp_rem = len - n;

        for (int i = 0; i < len; i++)  mem[s + 32'(4 * i)] = $urandom;
        for (int i = 0; i <= len; i++) mem[d + 32'(4 * i)] = $urandom;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{1'b0, s + 32'(4 * i), mem[s + 32'(4 * i)], 0, 0});
            exp_q.push_back('{1'b1, d + 32'(4 * i), mem[s + 32'(4 * i)], 0, 0});
        end
        for (int i = n; i <= len; i++) keep.push_back(mem[d + 32'(4 * i)]);

        base  = log_q.size();
        stab0 = stab_bad;

        @(negedge clk);
        i_src = src; i_dst = dst; i_len = 16'(len); i_start = 1'b1;
        done_at = 0; busy_cyc = 0; cs_cyc = 0; cyc = 0; rd_idx = 0; prev_cs = 1'b0;
        while (done_at == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            i_start = 1'b0;
            i_abort = 1'b0;
            if (o_busy) busy_cyc++;
            if (o_cs)   cs_cyc++;
            if (o_done) done_at = cyc;
            if (o_cs && !o_we && !prev_cs) rd_idx++;
            if (abort_k > 0 && rd_idx == abort_k && o_cs && !o_we) i_abort = 1'b1;
            if (spam && o_busy && (cyc % 3 == 0)) begin
                i_start = 1'b1;
                i_src   = $urandom;
                i_dst   = $urandom;
                i_len   = 16'($urandom_range(0, 9));
            end
            prev_cs = o_cs;
        end

        check({tag, ".done_seen"}, 64'(done_at != 0), 64'd1);
        check({tag, ".busy_span"}, 64'(busy_cyc), 64'(done_at - 1));
        check({tag, ".err"}, 64'(o_err), 64'(exp_err));
        check({tag, ".remaining"}, 64'(o_remaining), 64'(exp_rem));
        if (len == 0) begin
            check({tag, ".done_latency"}, 64'(done_at), 64'd2);
            check({tag, ".cs_cycles"}, 64'(cs_cyc), 64'd0);
        end
        if (exp_err) check({tag, ".cs_cycles"}, 64'(cs_cyc), 64'd8);

        @(negedge clk);
        check({tag, ".done_single"}, 64'(o_done), 64'd0);

        nlog = log_q.size() - base;
        check({tag, ".xfer_count"}, 64'(nlog), 64'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < nlog && i < exp_q.size(); i++) begin
            if (log_q[base + i].we   != exp_q[i].we ||
                log_q[base + i].addr != exp_q[i].addr ||
                log_q[base + i].data != exp_q[i].data) bad++;
        end
        check({tag, ".xfer_trace"}, 64'(bad), 64'd0);

        bad = 0;
        for (int i = 1; i < nlog; i++)
            if (log_q[base + i].t_start != log_q[base + i - 1].t_end + 2) bad++;
        check({tag, ".cs_gap"}, 64'(bad), 64'd0);
        check({tag, ".bus_stable"}, 64'(stab_bad - stab0), 64'd0);

        bad = 0;
        for (int i = 0; i < n; i++)
            if (mem[d + 32'(4 * i)] != mem[s + 32'(4 * i)]) bad++;
        for (int i = n; i <= len; i++)
            if (mem[d + 32'(4 * i)] != keep[i - n]) bad++;
        check({tag, ".dst_image"}, 64'(bad), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    int cyc, rl, rk;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.ctrl", 64'({o_cs, o_we, o_busy, o_done, o_err}), 64'd0);
        check("reset.addr", 64'(o_addr), 64'd0);
        check("reset.data", 64'(o_data_out), 64'd0);
        check("reset.remaining", 64'(o_remaining), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_copy("t1_basic", 32'h100, 32'h200, 3, 0, 1'b0);
        run_copy("t2_len0", 32'h300, 32'h400, 0, 0, 1'b0);
        run_copy("t3_abort", 32'h500, 32'h600, 4, 2, 1'b0);

        dead = 1'b1;
        run_copy("t4_timeout", 32'h700, 32'h800, 3, 0, 1'b0);
        dead = 1'b0;
        check("t4.err_sticky", 64'(o_err), 64'd1);

        run_copy("t5_wrap", 32'hFFFF_FFF8, 32'h2000, 3, 0, 1'b1);
        check("t5.rd3_addr", 64'(log_q[log_q.size() - 2].addr), 64'd0);

        for (int r = 0; r < 6; r++) begin
            rl = $urandom_range(1, 6);
            rk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, rl) : 0;
            run_copy($sformatf("rnd%0d", r),
                     32'(32'h10000 + r * 256 + $urandom_range(0, 3)),
                     32'(32'h40000 + r * 256 + $urandom_range(0, 3)),
                     rl, rk, 1'b0);
        end

        // reset in the middle of a write
        @(negedge clk);
        i_src = 32'h3000; i_dst = 32'h3100; i_len = 16'd4; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 0;
        while (!(o_cs && o_we) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("t6.reached_wr", 64'(o_cs && o_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6.async_ctrl", 64'({o_cs, o_we, o_busy, o_done, o_err}), 64'd0);
        check("t6.async_addr", 64'(o_addr), 64'd0);
        check("t6.async_data", 64'(o_data_out), 64'd0);
        check("t6.async_remaining", 64'(o_remaining), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_copy("t6_after_reset", 32'h3000, 32'h3100, 4, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_limn2600_dma_copier
`default_nettype wire
